// File: rtl/rbs_subtractor_pkg.sv
// Shared definitions for the sequential ripple-borrow subtractor and its
// companion ripple-carry adder: FSM state encoding and digit-count helpers.
package rbs_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a single-digit build still has a counter bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int num_digits(input int data_width, input int digit_width);
    return data_width / digit_width;
  endfunction

endpackage

// File: rtl/rbs_subtractor_digit_sub.sv
// Combinational WIDTH-bit ripple-borrow cell: {bout, d} = a - b - bin,
// built as a chain of 1-bit full subtractors.
module digit_sub #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  logic [WIDTH:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fs
    assign d[i]     = a[i] ^ b[i] ^ br[i];
    // Borrow out when b plus incoming borrow exceeds a at this bit.
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[WIDTH];

endmodule

// File: rtl/rbs_subtractor.sv
// Sequential ripple-borrow subtractor: out_sub_result = in_sub_a - in_sub_b,
// one DIGIT_WIDTH-bit digit per clock, LSB first, with start/busy/done handshake.
module rbs_subtractor
  import rbs_subtractor_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_sub_a,
  input  logic [DATA_WIDTH-1:0] in_sub_b,
  output logic [DATA_WIDTH-1:0] out_sub_result,
  output logic                  out_borrow,
  output logic                  out_busy,
  output logic                  out_done
);

  localparam int             NDIG = num_digits(DATA_WIDTH, DIGIT_WIDTH);
  localparam int             CW   = clog2_min1(NDIG);
  localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

  if (DATA_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_width
    $fatal(1, "rbs_subtractor: DATA_WIDTH must be a multiple of DIGIT_WIDTH");
  end

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q, res_q;
  logic                    bin_q, borrow_q, done_q;
  logic                    accept, last_digit;
  logic [DIGIT_WIDTH-1:0]  d;
  logic                    bout;

  // Operands shift right each cycle, so the active digit is always the low one.
  digit_sub #(.WIDTH(DIGIT_WIDTH)) u_digit (
    .a    (a_q[DIGIT_WIDTH-1:0]),
    .b    (b_q[DIGIT_WIDTH-1:0]),
    .bin  (bin_q),
    .d    (d),
    .bout (bout)
  );

  assign accept     = in_start && (state_q != RUN);
  assign last_digit = (state_q == RUN) && (cnt_q == LAST);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (in_start)   state_d = RUN;
      RUN:        if (last_digit) state_d = DONE;
      default:                    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: operand/result registers are plain flops, not a RAM, so they take the reset too.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_digit;
      if (accept) begin
        cnt_q    <= '0;
        a_q      <= in_sub_a;
        b_q      <= in_sub_b;
        res_q    <= '0;
        bin_q    <= 1'b0;
        borrow_q <= 1'b0;
      end else if (state_q == RUN) begin
        res_q[cnt_q*DIGIT_WIDTH +: DIGIT_WIDTH] <= d;
        a_q   <= a_q >> DIGIT_WIDTH;
        b_q   <= b_q >> DIGIT_WIDTH;
        bin_q <= bout;
        cnt_q <= cnt_q + 1'b1;
        if (last_digit) borrow_q <= bout;
      end
    end
  end

  assign out_sub_result = res_q;
  assign out_borrow     = borrow_q;
  assign out_busy       = (state_q == RUN);
  assign out_done       = done_q;

endmodule

// File: doc/rbs_subtractor.md
Name: rbs_subtractor

Overview:
Sequential ripple-borrow subtractor. It is the inverse-direction companion to the team's sequential ripple-carry adder. The block computes out_sub_result = in_sub_a - in_sub_b (mod 2^DATA_WIDTH), one DIGIT_WIDTH-bit digit per clock, LSB digit first, and reports the final borrow. It sits beside the adder in the arithmetic datapath and uses a start/busy/done handshake so a bench or controller can pair add/subtract checks.

Parameters:
DATA_WIDTH, 32, operand and result width in bits
DIGIT_WIDTH, 4, bits processed per clock; DATA_WIDTH % DIGIT_WIDTH must be 0 (elaboration-time check, fatal on violation)

Ports:
clk  input  1  single clock, rising-edge
resetn  input  1  reset; asynchronous, active-low
in_start  input  1  request an operation; sampled only when not busy
in_sub_a  input  DATA_WIDTH  minuend, captured on accepted start
in_sub_b  input  DATA_WIDTH  subtrahend, captured on accepted start
out_sub_result  output  DATA_WIDTH  difference; valid from out_done until next accepted start
out_borrow  output  1  final borrow (1 iff a < b unsigned); valid with result
out_busy  output  1  high while digits are being processed
out_done  output  1  one-cycle pulse when result/borrow become valid

Behaviour:
- NDIG = DATA_WIDTH/DIGIT_WIDTH; digit counter width = clog2(NDIG), minimum 1.
- States: IDLE, RUN, DONE.
- Reset (resetn=0, asynchronous): state IDLE, counter 0, operand regs 0, borrow reg 0. Outputs out_sub_result=0, out_borrow=0, out_busy=0, out_done=0. Applies immediately, including mid-RUN; the in-flight operation is discarded and no done pulse follows.
- IDLE or DONE with in_start=1 at edge E: capture a and b, clear borrow and counter, clear out_sub_result to 0, go to RUN. out_busy=1 from after E.
- RUN, each edge processes digit k=counter:
  - {bout, d} = a[k] - b[k] - bin, computed on DIGIT_WIDTH+1 bits.
  - Write d into result digit k; store bout as bin for the next digit; increment counter.
- After digit NDIG-1 (edge E+NDIG): latch out_borrow = bout, go to DONE, drop out_busy, and assert out_done for exactly the cycle following E+NDIG.
- Latency: result valid NDIG cycles after the start edge (8 with defaults).
- DONE: out_done deasserts on the next edge. Result and borrow hold. State stays DONE (functionally equivalent to IDLE) until the next start.
- Start in the out_done cycle is accepted, giving back-to-back operations with no bubble.
- in_start while out_busy=1 is ignored. Operand input changes during RUN have no effect, since operands are registered.
- Result bits for digits not yet processed read 0 while busy.
- Unsigned wrap: a < b gives the two's-complement wrap plus out_borrow=1. a == b gives 0 with borrow 0.

Decomposition:
- Shared package holds the state enum (IDLE, RUN, DONE) and the clog2 helper/NDIG localparam computation, shared with the sequential adder.
- One sub-module, digit_sub: purely combinational, DIGIT_WIDTH-bit ripple-borrow cell with ports a, b, bin, d, bout, built from 1-bit full subtractors.
- Top level holds the FSM, counter, operand/result registers and borrow register.

Test Plan:
- Reset: hold resetn=0 for 10 cycles -> all outputs 0. Release, no start -> outputs remain 0, out_busy=0.
- a=0x0000000A, b=0x00000003, start at edge E -> out_busy high for 8 cycles, out_done pulse after E+8, result 0x00000007, borrow 0.
- a=0x00000003, b=0x0000000A -> result 0xFFFFFFF9, borrow 1. Repeat with a=b=0x12345678 -> result 0, borrow 0.
- a=0x10000000, b=0x00000001 (borrow ripples through digits 0-6) -> result 0x0FFFFFFF, borrow 0. Same pair through the adder returns the original a.
- Start pulses at E+2 and E+5 during busy -> ignored, the first result is unchanged. A start during the out_done cycle -> accepted, second done exactly 8 cycles later.
- resetn pulled low asynchronously (mid-cycle) at digit 4 -> outputs 0 at once, no done pulse. After release, a=0xFFFFFFFF, b=0x00000001 -> 0xFFFFFFFE, borrow 0. Randomized 1000-op sweep checked against a - b.
